// File: rtl/store_buffer.sv
// Data-side store buffer: queues byte-lane encoded stores in a FIFO, drains them to
// data memory over req/ack, and stalls loads until the buffer is empty and the read returns.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_write_data,
   input  logic                   mem_wr,
   input  logic                   mem_sb,
   input  logic                   mem_sh,
   input  logic                   mem_rd,
   output logic [31:0]            mem_read_data,
   output logic                   stall,
   output logic                   dm_req,
   output logic                   dm_we,
   output logic [31:0]            dm_addr,
   output logic [31:0]            dm_wdata,
   output logic [3:0]             dm_be,
   input  logic                   dm_ack,
   input  logic [31:0]            dm_rdata,
   output logic [$clog2(DEPTH):0] sb_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

   state_t        state_q, state_d;
   logic [29:0]   fa_q [DEPTH];
   logic [31:0]   fd_q [DEPTH];
   logic [3:0]    fb_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          dm_req_q, dm_req_d, dm_we_q, dm_we_d;
   logic [31:0]   dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
   logic [3:0]    dm_be_q, dm_be_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          full, push, pop;

   function automatic logic [3:0] enc_be(input logic [1:0] a, input logic sb, input logic sh);
      if (sb)
         return 4'b0001 << a;
      else if (sh)
         return a[1] ? 4'b1100 : 4'b0011;
      else
         return 4'b1111;
   endfunction

   function automatic logic [31:0] enc_data(input logic [31:0] d, input logic sb, input logic sh);
      if (sb)
         return {4{d[7:0]}};
      else if (sh)
         return {2{d[15:0]}};
      else
         return d;
   endfunction

   // Full is judged on the registered count, so a same-cycle pop never frees a slot.
   assign full  = (cnt_q == FULL_CNT);
   assign push  = mem_wr & ~full;
   assign stall = (mem_wr & full) | (mem_rd & ~mem_wr & (state_q != RDONE));

   always_comb begin
      wp_d  = push ? wp_q + 1'b1 : wp_q;
      rp_d  = pop  ? rp_q + 1'b1 : rp_q;
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (!push && pop)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fa_q[wp_q] <= mem_addr[31:2];
         fd_q[wp_q] <= enc_data(mem_write_data, mem_sb, mem_sh);
         fb_q[wp_q] <= enc_be(mem_addr[1:0], mem_sb, mem_sh);
      end
   end

   always_comb begin
      state_d    = state_q;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      dm_be_d    = dm_be_q;
      rdata_d    = rdata_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            // Draining wins over a pending load; a store alongside mem_rd suppresses the load.
            if (cnt_q != '0) begin
               state_d    = WRITE;
               dm_req_d   = 1'b1;
               dm_we_d    = 1'b1;
               dm_addr_d  = {fa_q[rp_q], 2'b00};
               dm_wdata_d = fd_q[rp_q];
               dm_be_d    = fb_q[rp_q];
            end else if (mem_rd && !mem_wr) begin
               state_d   = READ;
               dm_req_d  = 1'b1;
               dm_we_d   = 1'b0;
               dm_addr_d = {mem_addr[31:2], 2'b00};
               dm_be_d   = 4'b1111;
            end
         end
         WRITE: begin
            if (dm_ack && dm_req_q) begin
               pop      = 1'b1;
               dm_req_d = 1'b0;
               state_d  = IDLE;
            end
         end
         READ: begin
            if (dm_ack && dm_req_q) begin
               rdata_d  = dm_rdata;
               dm_req_d = 1'b0;
               state_d  = RDONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wp_q       <= '0;
         rp_q       <= '0;
         cnt_q      <= '0;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         dm_be_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         cnt_q      <= cnt_d;
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         dm_be_q    <= dm_be_d;
         rdata_q    <= rdata_d;
      end
   end

   assign mem_read_data = rdata_q;
   assign dm_req        = dm_req_q;
   assign dm_we         = dm_we_q;
   assign dm_addr       = dm_addr_q;
   assign dm_wdata      = dm_wdata_q;
   assign dm_be         = dm_be_q;
   assign sb_count      = cnt_q;

endmodule
